// File: rtl/noc_local_ni_if.sv
// Core/router-facing signal bundle of the local network interface.
// The NI drives the master modport; the core/router environment uses the slave modport.
interface noc_local_ni_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_dest;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        rx_last;
    logic [36:0] noc_in_data;
    logic        noc_in_req;
    logic        noc_in_ack;
    logic [36:0] noc_out_data;
    logic        noc_out_req;
    logic        noc_out_ack;

    modport master (
        input  tx_valid, tx_dest, tx_data, tx_last, rx_ready,
               noc_in_ack, noc_out_data, noc_out_req,
        output tx_ready, rx_valid, rx_data, rx_last,
               noc_in_data, noc_in_req, noc_out_ack
    );

    modport slave (
        output tx_valid, tx_dest, tx_data, tx_last, rx_ready,
               noc_in_ack, noc_out_data, noc_out_req,
        input  tx_ready, rx_valid, rx_data, rx_last,
               noc_in_data, noc_in_req, noc_out_ack
    );
endinterface

// File: rtl/noc_local_ni.sv
// Local network interface: TX/RX flit FIFOs between a core and a router local port,
// with four-phase req/ack handshakes on the router side.
module noc_local_ni #(
    parameter logic [3:0] POSITION   = 4'b0101,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    noc_local_ni_if.master bus,
    output logic [15:0]    o_tx_count,
    output logic [15:0]    o_rx_count,
    output logic           o_err_misroute
);
    localparam int ENTRIES = 1 << FIFO_DEPTH;

    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DROP} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_ACK}          rx_state_t;

    tx_state_t           r_tx_state, w_tx_next;
    rx_state_t           r_rx_state, w_rx_next;
    logic [36:0]         r_tx_mem [ENTRIES];
    logic [32:0]         r_rx_mem [ENTRIES];
    logic [FIFO_DEPTH:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic                r_tx_avail;
    logic [36:0]         r_noc_in_data;
    logic [15:0]         r_tx_count, r_rx_count;
    logic                r_err;
    logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                w_tx_push, w_tx_pop, w_tx_load, w_rx_push, w_rx_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp == {~r_tx_rp[FIFO_DEPTH], r_tx_rp[FIFO_DEPTH-1:0]});
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp == {~r_rx_rp[FIFO_DEPTH], r_rx_rp[FIFO_DEPTH-1:0]});

    assign w_tx_push = bus.tx_valid && !w_tx_full;
    assign w_rx_pop  = bus.rx_ready && !w_rx_empty;

    assign bus.tx_ready    = !w_tx_full;
    assign bus.rx_valid    = !w_rx_empty;
    assign {bus.rx_data, bus.rx_last} = r_rx_mem[r_rx_rp[FIFO_DEPTH-1:0]];
    assign bus.noc_in_data = r_noc_in_data;
    assign bus.noc_in_req  = (r_tx_state == TX_REQ);
    assign bus.noc_out_ack = (r_rx_state == RX_ACK);
    assign o_tx_count      = r_tx_count;
    assign o_rx_count      = r_rx_count;
    assign o_err_misroute  = r_err;

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_DEPTH-1:0]] <= {bus.tx_data, bus.tx_last, bus.tx_dest};
    end

    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_DEPTH-1:0]] <= bus.noc_out_data[36:4];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_rx_state <= RX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
        end
    end

    // r_tx_avail lags FIFO occupancy by one edge, giving the two-cycle push-to-request latency.
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_load = 1'b0;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (r_tx_avail) begin
                w_tx_load = 1'b1;
                w_tx_next = TX_REQ;
            end
            TX_REQ: if (bus.noc_in_ack) begin
                w_tx_pop  = 1'b1;
                w_tx_next = TX_DROP;
            end
            TX_DROP: if (!bus.noc_in_ack) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (bus.noc_out_req && !w_rx_full) begin
                w_rx_push = 1'b1;
                w_rx_next = RX_ACK;
            end
            RX_ACK:  if (!bus.noc_out_req) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_wp       <= '0;
            r_tx_rp       <= '0;
            r_rx_wp       <= '0;
            r_rx_rp       <= '0;
            r_tx_avail    <= 1'b0;
            r_noc_in_data <= '0;
            r_tx_count    <= '0;
            r_rx_count    <= '0;
            r_err         <= 1'b0;
        end else begin
            r_tx_avail <= !w_tx_empty;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) begin
                r_tx_rp    <= r_tx_rp + 1'b1;
                r_tx_count <= r_tx_count + 16'd1;
            end
            if (w_tx_load) r_noc_in_data <= r_tx_mem[r_tx_rp[FIFO_DEPTH-1:0]];
            if (w_rx_push) begin
                r_rx_wp    <= r_rx_wp + 1'b1;
                r_rx_count <= r_rx_count + 16'd1;
                if (bus.noc_out_data[3:0] != POSITION) r_err <= 1'b1;
            end
            if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: queue-based scoreboard checked every cycle plus directed literal checks.
module tb_noc_local_ni;
    localparam int DEPTH = 4;
    localparam logic [3:0] POS = 4'b0101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tx_count, rx_count;
    logic        err_misroute;
    int          n_vec = 0;
    int          n_err = 0;

    noc_local_ni_if bus();

    noc_local_ni #(.POSITION(POS), .FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus),
        .o_tx_count(tx_count), .o_rx_count(rx_count), .o_err_misroute(err_misroute)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] fl(input logic [31:0] d, input logic l, input logic [3:0] dst);
        return {d, l, dst};
    endfunction

    // Scoreboard: flits the NI holds, counters and protocol phase, updated per edge.
    logic [36:0] txq[$];
    logic [32:0] rxq[$];
    logic [15:0] m_tx_cnt, m_rx_cnt;
    logic        m_err, m_acking, m_drop;
    bit          armed = 0;

    always @(posedge clk) begin
        logic tx_acc, tx_hs, rx_acc, rx_pop;
        if (reset) begin
            txq.delete(); rxq.delete();
            m_tx_cnt = 0; m_rx_cnt = 0; m_err = 0; m_acking = 0; m_drop = 0;
            armed = 1;
        end else if (armed) begin
            tx_acc = bus.tx_valid && (txq.size() < DEPTH);
            tx_hs  = bus.noc_in_req && bus.noc_in_ack;
            rx_pop = bus.rx_ready && (rxq.size() > 0);
            rx_acc = !m_acking && bus.noc_out_req && (rxq.size() < DEPTH);
            if (tx_hs && txq.size() > 0) begin
                void'(txq.pop_front());
                m_tx_cnt++;
            end
            if (tx_acc) txq.push_back({bus.tx_data, bus.tx_last, bus.tx_dest});
            if (tx_hs) m_drop = 1;
            else if (!bus.noc_in_ack) m_drop = 0;
            if (rx_pop) void'(rxq.pop_front());
            if (m_acking && !bus.noc_out_req) m_acking = 0;
            else if (rx_acc) begin
                m_acking = 1;
                rxq.push_back(bus.noc_out_data[36:4]);
                m_rx_cnt++;
                if (bus.noc_out_data[3:0] != POS) m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("tx_ready", bus.tx_ready, txq.size() < DEPTH);
            chk("rx_valid", bus.rx_valid, rxq.size() != 0);
            if (rxq.size() != 0) chk("rx_head", {bus.rx_data, bus.rx_last}, rxq[0]);
            chk("noc_out_ack", bus.noc_out_ack, m_acking);
            if (txq.size() == 0) chk("noc_in_req_empty", bus.noc_in_req, 0);
            else if (bus.noc_in_req) chk("noc_in_data", bus.noc_in_data, txq[0]);
            if (m_drop) chk("noc_in_req_drop", bus.noc_in_req, 0);
            chk("tx_count", tx_count, m_tx_cnt);
            chk("rx_count", rx_count, m_rx_cnt);
            chk("err_misroute", err_misroute, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_hs(input logic [36:0] exp);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.noc_in_req) begin got = 1; break; end
            tick();
        end
        chk("tx_hs_req_seen", got, 1);
        chk("tx_hs_data", bus.noc_in_data, exp);
        bus.noc_in_ack = 1;
        tick();
        chk("tx_hs_req_drop", bus.noc_in_req, 0);
        bus.noc_in_ack = 0;
        tick();
    endtask

    task automatic rx_offer(input logic [36:0] f);
        bit got = 0;
        bus.noc_out_data = f;
        bus.noc_out_req  = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.noc_out_ack) begin got = 1; break; end
        end
        chk("rx_offer_ack", got, 1);
        bus.noc_out_req = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.noc_out_ack) begin got = 1; break; end
        end
        chk("rx_offer_ack_drop", got, 1);
    endtask

    task automatic drain(input int n);
        bus.rx_ready = 1;
        repeat (n) tick();
        bus.rx_ready = 0;
    endtask

    logic [36:0] exp_tx[4];

    initial begin
        bit got;
        bus.tx_valid = 0; bus.tx_dest = 0; bus.tx_data = 0; bus.tx_last = 0;
        bus.rx_ready = 0; bus.noc_in_ack = 0; bus.noc_out_data = 0; bus.noc_out_req = 0;
        reset = 1;
        tick(); tick();
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_noc_in_req", bus.noc_in_req, 0);
        chk("rst_noc_out_ack", bus.noc_out_ack, 0);
        chk("rst_noc_in_data", bus.noc_in_data, 0);
        chk("rst_counts", {tx_count, rx_count}, 0);
        chk("rst_err", err_misroute, 0);
        reset = 0;
        tick();

        // Single flit: two-cycle latency, req drops after ack, ack held 3 cycles.
        bus.tx_valid = 1; bus.tx_dest = 4'b0110; bus.tx_data = 32'hDEADBEEF; bus.tx_last = 1;
        tick();
        bus.tx_valid = 0;
        tick();
        chk("lat_req_n1", bus.noc_in_req, 0);
        tick();
        chk("lat_req_n2", bus.noc_in_req, 1);
        chk("lat_data", bus.noc_in_data, 37'h1BD5B7DDF6);
        bus.noc_in_ack = 1;
        tick();
        chk("ack_req_drop", bus.noc_in_req, 0);
        chk("ack_tx_count", tx_count, 1);
        tick(); tick();
        chk("drop_hold_req", bus.noc_in_req, 0);
        bus.noc_in_ack = 0;
        tick(); tick();

        // Fill TX FIFO, reject a fifth flit, then drain in order.
        for (int i = 0; i < 4; i++) begin
            exp_tx[i] = fl(32'hA000_0000 + 32'(i), i == 3, 4'(i + 1));
            bus.tx_valid = 1; bus.tx_data = 32'hA000_0000 + 32'(i);
            bus.tx_last = (i == 3); bus.tx_dest = 4'(i + 1);
            tick();
        end
        chk("full_tx_ready", bus.tx_ready, 0);
        bus.tx_data = 32'h5555_5555; bus.tx_last = 0; bus.tx_dest = 4'hF;
        tick();
        chk("full_5th_ready", bus.tx_ready, 0);
        tick();
        bus.tx_valid = 0;
        for (int i = 0; i < 4; i++) tx_hs(exp_tx[i]);
        tick();
        chk("drained_tx_ready", bus.tx_ready, 1);
        chk("drained_tx_count", tx_count, 5);

        // Single received flit to this node.
        bus.noc_out_data = fl(32'h12345678, 0, 4'b0101);
        bus.noc_out_req = 1;
        tick();
        chk("rx1_ack", bus.noc_out_ack, 1);
        chk("rx1_valid", bus.rx_valid, 1);
        chk("rx1_data", bus.rx_data, 32'h12345678);
        bus.noc_out_req = 0;
        tick();
        chk("rx1_ack_drop", bus.noc_out_ack, 0);
        chk("rx1_err", err_misroute, 0);
        drain(1);
        chk("rx1_drained", bus.rx_valid, 0);

        // RX full stalls the router until the core pops.
        for (int i = 0; i < 4; i++) rx_offer(fl(32'hB000_0000 + 32'(i), i == 3, POS));
        bus.noc_out_data = fl(32'hB000_0004, 1, POS);
        bus.noc_out_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rxfull_ack_low", bus.noc_out_ack, 0);
        end
        chk("rxfull_head", bus.rx_data, 32'hB000_0000);
        drain(1);
        got = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.noc_out_ack) begin got = 1; break; end
            tick();
        end
        if (!got) got = bus.noc_out_ack;
        chk("rxfull_ack_after_pop", got, 1);
        bus.noc_out_req = 0;
        tick(); tick();
        chk("rxfull_rx_count", rx_count, 6);
        drain(4);

        // Misrouted flit sets a sticky error that survives good flits.
        rx_offer(fl(32'hC0DE_0000, 1, 4'b0000));
        chk("mis_err_set", err_misroute, 1);
        rx_offer(fl(32'hC0DE_0001, 1, POS));
        chk("mis_err_held", err_misroute, 1);
        drain(2);
        chk("mis_err_after_drain", err_misroute, 1);

        // Both sides mid-handshake in parallel, then reset aborts them.
        bus.tx_valid = 1; bus.tx_data = 32'hFEED_F00D; bus.tx_last = 1; bus.tx_dest = 4'b1010;
        bus.noc_out_data = fl(32'h0BAD_CAFE, 0, POS);
        bus.noc_out_req = 1;
        tick();
        bus.tx_valid = 0;
        tick(); tick();
        chk("par_noc_in_req", bus.noc_in_req, 1);
        chk("par_noc_out_ack", bus.noc_out_ack, 1);
        reset = 1;
        bus.noc_out_req = 0;
        tick();
        chk("rst2_noc_in_req", bus.noc_in_req, 0);
        chk("rst2_noc_out_ack", bus.noc_out_ack, 0);
        chk("rst2_counts", {tx_count, rx_count}, 0);
        chk("rst2_rx_valid", bus.rx_valid, 0);
        chk("rst2_tx_ready", bus.tx_ready, 1);
        chk("rst2_err", err_misroute, 0);
        reset = 0;
        repeat (4) tick();
        chk("post_rst_req", bus.noc_in_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/noc_local_ni.md
NOC_LOCAL_NI -- requirements
Module: noc_local_ni

Interface
REQ-001 Parameters SHALL be: POSITION, default 4'b0101, node address {Y[3:2],X[1:0]}; FIFO_DEPTH, default 2, log2 of entries per FIFO; flit width is fixed at 37.
REQ-002 Flit format SHALL be: [36:5] payload, [4] tail, [3:0] destination {Y,X}.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_valid  input  1  core offers a flit.
REQ-006 tx_ready  output  1  TX FIFO not full.
REQ-007 tx_dest  input  4  destination address.
REQ-008 tx_data  input  32  payload.
REQ-009 tx_last  input  1  tail flag.
REQ-010 rx_valid  output  1  RX FIFO not empty.
REQ-011 rx_ready  input  1  core consumes head flit.
REQ-012 rx_data  output  32  head payload.
REQ-013 rx_last  output  1  head tail flag.
REQ-014 noc_in_data  output  37  flit to router local input (dataInL).
REQ-015 noc_in_req  output  1  request to router (Inr_L).
REQ-016 noc_in_ack  input  1  router accept (Inw_L).
REQ-017 noc_out_data  input  37  flit from router local output (dataOutL).
REQ-018 noc_out_req  input  1  router offers flit (Outr_L).
REQ-019 noc_out_ack  output  1  NI accept (Outw_L).
REQ-020 tx_count, rx_count  output  16 each  flits sent / received, wrap at 16'hFFFF -> 0.
REQ-021 err_misroute  output  1  sticky: received flit whose [3:0] != POSITION.

Function
REQ-022 Push to the TX FIFO SHALL occur when tx_valid && tx_ready, storing {tx_data, tx_last, tx_dest}; tx_ready SHALL equal !tx_full, registered-state only, with no combinational path from pops.
REQ-023 TX FIFO pop and push in the same cycle SHALL both take effect; pointers SHALL wrap modulo 2**FIFO_DEPTH.
REQ-024 TX FSM states SHALL be TX_IDLE, TX_REQ, TX_DROP.
REQ-025 In TX_IDLE with the FIFO non-empty, the block SHALL load the head into noc_in_data, set noc_in_req=1 and go to TX_REQ.
REQ-026 Latency SHALL be two cycles: a push at edge n into an empty FIFO with the FSM idle gives noc_in_req=1 after edge n+2.
REQ-027 In TX_REQ, noc_in_data SHALL be held stable; on noc_in_ack=1 the block SHALL set noc_in_req=0, pop the FIFO, increment tx_count and go to TX_DROP.
REQ-028 In TX_DROP the block SHALL wait for noc_in_ack=0, then go to TX_IDLE; a new request SHALL NOT be raised while noc_in_ack=1.
REQ-029 RX FSM states SHALL be RX_IDLE and RX_ACK.
REQ-030 In RX_IDLE, if noc_out_req=1 and the RX FIFO is not full, the block SHALL push noc_out_data, set noc_out_ack=1, increment rx_count and go to RX_ACK.
REQ-031 In RX_IDLE with the RX FIFO full, noc_out_ack SHALL stay 0 and the router SHALL be stalled.
REQ-032 In RX_ACK, noc_out_ack SHALL stay 1 until noc_out_req=0 is sampled; then noc_out_ack=0 and the FSM SHALL return to RX_IDLE, giving exactly one push per handshake.
REQ-033 RX pop SHALL occur when rx_valid && rx_ready; rx_data/rx_last SHALL come from the head entry; a simultaneous push and pop SHALL both take effect.
REQ-034 On RX push, if noc_out_data[3:0] != POSITION, err_misroute SHALL be set to 1 and held until reset; the flit SHALL still be stored.
REQ-035 The TX and RX paths SHALL be independent and SHALL be able to handshake in the same cycle.

Reset
REQ-036 reset=1 at an edge SHALL clear both FIFOs, set both FSMs to idle and drive tx_ready=1, rx_valid=0, noc_in_req=0, noc_out_ack=0, noc_in_data=0, tx_count=0, rx_count=0, err_misroute=0.
REQ-037 Reset mid-handshake SHALL abort it immediately; flits in flight SHALL be discarded.

Verification
REQ-038 Push {dest=4'b0110, data=32'hDEADBEEF, last=1} -> after 2 cycles noc_in_req=1, noc_in_data=37'h1BD5B7DDF6; ack held 3 cycles -> req drops the cycle after ack rises; tx_count=1.
REQ-039 Push 4 flits with no ack -> tx_ready=0 after the 4th; a 5th tx_valid is not accepted; after 4 handshakes flits emerge in order and tx_ready=1.
REQ-040 Router offers a flit with [3:0]=4'b0101, payload 32'h12345678 -> noc_out_ack=1 next cycle, rx_valid=1, rx_data=32'h12345678; noc_out_req drop -> ack drops next cycle; err_misroute=0.
REQ-041 RX FIFO full (4 flits, rx_ready=0), router offers a 5th -> noc_out_ack stays 0; one rx pop -> ack rises within 2 cycles.
REQ-042 Received flit with [3:0]=4'b0000 -> err_misroute=1 and held through later good flits until reset.
REQ-043 Reset asserted while noc_in_req=1 and noc_out_ack=1 -> both 0 next cycle, counters 0, rx_valid=0, tx_ready=1.
